// File: rtl/cpu_controller_pkg.sv
// Shared definitions for the instruction controller: instruction field codes,
// FSM state encoding, datapath control codes and the control-bundle type.
package cpu_controller_pkg;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] VSEL_MDATA  = 2'b00;
    localparam logic [1:0] VSEL_SXIMM8 = 2'b01;
    localparam logic [1:0] VSEL_PC     = 2'b10;
    localparam logic [1:0] VSEL_C      = 2'b11;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL1 = 2'b01;
    localparam logic [1:0] SH_LSR1 = 2'b10;
    localparam logic [1:0] SH_ASR1 = 2'b11;

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_GET_A     = 3'd2,
        S_GET_B     = 3'd3,
        S_COMPUTE   = 3'd4,
        S_WRITE_REG = 3'd5,
        S_WRITE_IMM = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        K_MOV_IMM,
        K_MOV_REG,
        K_ADD,
        K_CMP,
        K_AND,
        K_MVN,
        K_UNDEF
    } kind_e;

    typedef struct packed {
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic [1:0] vsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] shift;
        logic [1:0] aluop;
    } ctrl_t;

    function automatic kind_e classify(input logic [2:0] opcode, input logic [1:0] op);
        kind_e k;
        k = K_UNDEF;
        if (opcode == OPC_MOV) begin
            if (op == OP_MOV_IMM)      k = K_MOV_IMM;
            else if (op == OP_MOV_REG) k = K_MOV_REG;
        end else if (opcode == OPC_ALU) begin
            case (op)
                OP_ADD:  k = K_ADD;
                OP_CMP:  k = K_CMP;
                OP_AND:  k = K_AND;
                default: k = K_MVN;
            endcase
        end
        return k;
    endfunction

endpackage

// File: rtl/cpu_controller_dec.sv
// Combinational instruction field splitter with sign-extended immediates.
module instr_dec
    import cpu_controller_pkg::*;
(
    input  logic [15:0] ir_i,
    output logic [2:0]  opcode_o,
    output logic [1:0]  op_o,
    output logic [2:0]  rn_o,
    output logic [2:0]  rd_o,
    output logic [1:0]  sh_o,
    output logic [2:0]  rm_o,
    output logic [15:0] sximm8_o,
    output logic [15:0] sximm5_o
);

    always_comb begin
        opcode_o = ir_i[15:13];
        op_o     = ir_i[12:11];
        rn_o     = ir_i[10:8];
        rd_o     = ir_i[7:5];
        sh_o     = ir_i[4:3];
        rm_o     = ir_i[2:0];
        sximm8_o = {{8{ir_i[7]}}, ir_i[7:0]};
        sximm5_o = {{11{ir_i[4]}}, ir_i[4:0]};
    end

endmodule

// File: rtl/cpu_controller.sv
// Instruction register plus Moore control FSM sequencing the register/ALU
// datapath one instruction at a time; all control outputs are registered.
module cpu_controller
    import cpu_controller_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [1:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    logic [15:0] ir_q;
    state_e      state_q, state_d;
    ctrl_t       ctrl_q, ctrl_d;
    logic        w_q;

    logic [2:0]  opcode, rn, rd, rm;
    logic [1:0]  op, sh;
    kind_e       kind;

    instr_dec u_dec (
        .ir_i     (ir_q),
        .opcode_o (opcode),
        .op_o     (op),
        .rn_o     (rn),
        .rd_o     (rd),
        .sh_o     (sh),
        .rm_o     (rm),
        .sximm8_o (sximm8),
        .sximm5_o (sximm5)
    );

    assign kind = classify(opcode, op);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q <= '0;
        end else if (load && state_q == S_WAIT) begin
            ir_q <= in;
        end
    end

    always_comb begin
        state_d = S_WAIT;
        case (state_q)
            S_WAIT:   state_d = s ? S_DECODE : S_WAIT;
            S_DECODE: begin
                case (kind)
                    K_MOV_IMM:           state_d = S_WRITE_IMM;
                    K_MOV_REG, K_MVN:    state_d = S_GET_B;
                    K_ADD, K_CMP, K_AND: state_d = S_GET_A;
                    default:             state_d = S_WAIT;
                endcase
            end
            S_GET_A:   state_d = S_GET_B;
            S_GET_B:   state_d = S_COMPUTE;
            S_COMPUTE: state_d = (kind == K_CMP) ? S_WAIT : S_WRITE_REG;
            default:   state_d = S_WAIT;
        endcase
    end

    // Outputs are computed for the state being entered so they appear registered
    // in that state; IR only changes in WAIT, so the fields are stable by then.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            S_GET_A: begin
                ctrl_d.readnum = rn;
                ctrl_d.loada   = 1'b1;
            end
            S_GET_B: begin
                ctrl_d.readnum = rm;
                ctrl_d.loadb   = 1'b1;
            end
            S_COMPUTE: begin
                ctrl_d.shift = sh;
                ctrl_d.bsel  = 1'b0;
                case (kind)
                    K_MOV_REG: begin
                        ctrl_d.asel  = 1'b1;
                        ctrl_d.aluop = ALU_ADD;
                        ctrl_d.loadc = 1'b1;
                    end
                    K_MVN: begin
                        ctrl_d.asel  = 1'b1;
                        ctrl_d.aluop = ALU_NOTB;
                        ctrl_d.loadc = 1'b1;
                    end
                    K_AND: begin
                        ctrl_d.aluop = ALU_AND;
                        ctrl_d.loadc = 1'b1;
                    end
                    K_CMP: begin
                        ctrl_d.aluop = ALU_SUB;
                        ctrl_d.loads = 1'b1;
                    end
                    default: begin
                        ctrl_d.aluop = ALU_ADD;
                        ctrl_d.loadc = 1'b1;
                    end
                endcase
            end
            S_WRITE_REG: begin
                ctrl_d.writenum = rd;
                ctrl_d.vsel     = VSEL_C;
                ctrl_d.write    = 1'b1;
            end
            S_WRITE_IMM: begin
                ctrl_d.writenum = rn;
                ctrl_d.vsel     = VSEL_SXIMM8;
                ctrl_d.write    = 1'b1;
            end
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_WAIT;
            ctrl_q  <= '0;
            w_q     <= 1'b1;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            w_q     <= (state_d == S_WAIT);
        end
    end

    assign w        = w_q;
    assign readnum  = ctrl_q.readnum;
    assign writenum = ctrl_q.writenum;
    assign write    = ctrl_q.write;
    assign vsel     = ctrl_q.vsel;
    assign loada    = ctrl_q.loada;
    assign loadb    = ctrl_q.loadb;
    assign loadc    = ctrl_q.loadc;
    assign loads    = ctrl_q.loads;
    assign asel     = ctrl_q.asel;
    assign bsel     = ctrl_q.bsel;
    assign shift    = ctrl_q.shift;
    assign ALUop    = ctrl_q.aluop;

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench: per-instruction expected control traces built from the
// instruction semantics, compared cycle by cycle against the controller.
module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        reset, s, load;
    logic [15:0] in;
    logic        w, write, loada, loadb, loadc, loads, asel, bsel;
    logic [2:0]  readnum, writenum;
    logic [1:0]  vsel, shift, ALUop;
    logic [15:0] sximm8, sximm5;

    cpu_controller dut (
        .clk(clk), .reset(reset), .s(s), .load(load), .in(in), .w(w),
        .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop),
        .sximm8(sximm8), .sximm5(sximm5)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       w;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic [1:0] vsel;
        logic       loada, loadb, loadc, loads, asel, bsel;
        logic [1:0] shift;
        logic [1:0] aluop;
    } snap_t;
    typedef snap_t snapq_t[$];

    snap_t       cur;
    snap_t       idle;
    logic [15:0] ir_m;
    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    always_comb begin
        cur          = '0;
        cur.w        = w;
        cur.readnum  = readnum;
        cur.writenum = writenum;
        cur.write    = write;
        cur.vsel     = vsel;
        cur.loada    = loada;
        cur.loadb    = loadb;
        cur.loadc    = loadc;
        cur.loads    = loads;
        cur.asel     = asel;
        cur.bsel     = bsel;
        cur.shift    = shift;
        cur.aluop    = ALUop;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Expected snapshot per cycle after s is sampled, ending with the idle WAIT cycle.
    function automatic snapq_t trace_of(input logic [15:0] ir);
        snapq_t t;
        snap_t  e;
        int     opc, op;
        opc = int'(ir[15:13]);
        op  = int'(ir[12:11]);
        e = '0;
        t.push_back(e);
        if (opc == 6 && op == 2) begin
            e = '0; e.writenum = ir[10:8]; e.vsel = 2'd1; e.write = 1'b1;
            t.push_back(e);
        end else if ((opc == 6 && op == 0) || opc == 5) begin
            if (opc == 5 && op != 3) begin
                e = '0; e.readnum = ir[10:8]; e.loada = 1'b1;
                t.push_back(e);
            end
            e = '0; e.readnum = ir[2:0]; e.loadb = 1'b1;
            t.push_back(e);
            e = '0; e.shift = ir[4:3];
            if (opc == 6)       begin e.asel = 1'b1; e.aluop = 2'd0; e.loadc = 1'b1; end
            else if (op == 3)   begin e.asel = 1'b1; e.aluop = 2'd3; e.loadc = 1'b1; end
            else if (op == 0)   begin e.aluop = 2'd0; e.loadc = 1'b1; end
            else if (op == 2)   begin e.aluop = 2'd2; e.loadc = 1'b1; end
            else                begin e.aluop = 2'd1; e.loads = 1'b1; end
            t.push_back(e);
            if (!(opc == 5 && op == 1)) begin
                e = '0; e.writenum = ir[7:5]; e.vsel = 2'd3; e.write = 1'b1;
                t.push_back(e);
            end
        end
        t.push_back(idle);
        return t;
    endfunction

    task automatic sample(input string tag, input snap_t exp);
        logic [15:0] x8, x5;
        x8 = 16'($signed(ir_m[7:0]));
        x5 = 16'($signed(ir_m[4:0]));
        check(tag, 32'(cur), 32'(exp));
        check({tag, "/sximm8"}, 32'(sximm8), 32'(x8));
        check({tag, "/sximm5"}, 32'(sximm5), 32'(x5));
    endtask

    // noise: 0 quiet, 1 random load/s/in while busy, 2 load=1 with in=0xD007 while busy
    task automatic run_instr(input logic [15:0] word, input bit do_load, input int noise,
                             input int reset_at);
        snapq_t t;
        in = word; load = do_load; s = 1'b1;
        @(posedge clk); #1;
        if (do_load) ir_m = word;
        s = 1'b0; load = 1'b0;
        t = trace_of(ir_m);
        for (int i = 0; i < t.size(); i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            sample($sformatf("ir%04h_step%0d", ir_m, i), t[i]);
            if (i == reset_at) begin
                s = 1'b0; load = 1'b0;
                reset = 1'b1; #1;
                ir_m = '0;
                sample("reset_async", idle);
                #2 reset = 1'b0;
                @(posedge clk); #1;
                sample("post_reset", idle);
                return;
            end
            if (noise == 1 && !t[i].w) begin
                load = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1)); in = 16'($urandom);
            end else if (noise == 2 && !t[i].w) begin
                load = 1'b1; in = 16'hD007;
            end else begin
                load = 1'b0; s = 1'b0;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            sample("idle", idle);
        end
    endtask

    initial begin
        logic [15:0] word;
        int          ra;
        snapq_t      tr;
        idle = '0; idle.w = 1'b1;
        ir_m = '0; reset = 1'b1; s = 1'b0; load = 1'b0; in = '0;
        repeat (2) @(posedge clk);
        #1 sample("in_reset", idle);
        reset = 1'b0;
        idle_cycles(1);

        run_instr(16'hD007, 1'b1, 0, -1);
        run_instr(16'hD5FF, 1'b1, 0, -1);
        run_instr(16'hA140, 1'b1, 0, -1);
        run_instr(16'hA908, 1'b1, 0, -1);
        run_instr(16'hB861, 1'b1, 0, -1);
        run_instr(16'hA140, 1'b1, 2, -1);
        run_instr(16'hA140, 1'b0, 0, -1);
        run_instr(16'hA140, 1'b1, 0, 2);
        run_instr(16'h0000, 1'b0, 0, -1);
        idle_cycles(2);

        for (int n = 0; n < 250; n++) begin
            case ($urandom_range(0, 3))
                0:       word = {3'b110, 2'b10, 11'($urandom)};
                1:       word = {3'b110, 2'b00, 11'($urandom)};
                2:       word = {3'b101, 13'($urandom)};
                default: word = 16'($urandom);
            endcase
            ra = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 5)) : -1;
            run_instr(word, $urandom_range(0, 5) != 0, int'($urandom_range(0, 1)), ra);
            idle_cycles(int'($urandom_range(0, 2)));
        end

        tr = trace_of(16'hA140);
        check("add_len", 32'(tr.size()), 32'd6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
